// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-and-add multiplier, one partial
// product per clock through a single ripple nAdder.

module nAdder #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  always_comb begin : ripple
    logic c;
    c = Cin;
    Sum = '0;
    for (int i = 0; i < N; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c;
      c = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule

module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   phi_q, phi_d;
  logic [N-1:0]   plo_q, plo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] prod_q, prod_d;

  logic [N-1:0] add_b;
  logic [N-1:0] sum;
  logic         cout;
  logic         last;

  assign last  = (cnt_q == CW'(N - 1));
  assign add_b = plo_q[0] ? m_q : '0;

  nAdder #(.N(N)) u_add (
    .A    (phi_q),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    m_d    = m_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    unique case (1'b1)
      (state_q == IDLE) && start: begin
        m_d   = multiplicand;
        plo_d = multiplier;
        phi_d = '0;
        cnt_d = '0;
      end
      state_q == CALC: begin
        // add-then-shift: carry-out lands in the top bit, never dropped
        phi_d = {cout, sum[N-1:1]};
        plo_d = {sum[0], plo_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last) prod_d = {cout, sum, plo_q[N-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q    <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      m_q    <= m_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier at N=8 and N=4, reference is
// plain a*b with the expected completion cycle.

module tb_shift_add_multiplier;

  typedef struct {
    logic [15:0] p;
    int          due;
  } exp_t;

  logic clk = 0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vecs = 0;
  int errs = 0;

  exp_t q8[$];
  exp_t q4[$];

  logic        rst8_n, st8, busy8, done8;
  logic [7:0]  mc8, mp8;
  logic [15:0] prod8;
  logic        rst4_n, st4, busy4, done4;
  logic [3:0]  mc4, mp4;
  logic [7:0]  prod4;
  logic [15:0] last8;

  shift_add_multiplier #(.N(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst8_n),
    .start        (st8),
    .multiplicand (mc8),
    .multiplier   (mp8),
    .busy         (busy8),
    .done         (done8),
    .product      (prod8)
  );

  shift_add_multiplier #(.N(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst4_n),
    .start        (st4),
    .multiplicand (mc4),
    .multiplier   (mp4),
    .busy         (busy4),
    .done         (done4),
    .product      (prod4)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst8_n === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("n8_spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("n8_product", {16'h0, prod8}, {16'h0, e.p});
        chk("n8_done_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (rst4_n === 1'b1 && done4 === 1'b1) begin
      if (q4.size() == 0) begin
        chk("n4_spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("n4_product", {24'h0, prod4}, {16'h0, e.p});
        chk("n4_done_cycle", cyc, e.due);
      end
    end
  end

  // called at a negedge with dut8 idle; returns at the negedge after done
  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int t, bc;
    bit seen;
    exp_t e;
    mc8 = a;
    mp8 = b;
    st8 = 1;
    @(posedge clk);
    #1;
    t = cyc;
    e.p = 16'(a) * 16'(b);
    e.due = t + 8;
    q8.push_back(e);
    st8 = 0;
    mc8 = 8'($urandom);
    mp8 = 8'($urandom);
    bc = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy8) bc++;
      if (done8) seen = 1;
      else chk("n8_hold", {16'h0, prod8}, {16'h0, last8});
    end
    if (!seen) chk("n8_timeout", 0, 1);
    chk("n8_busy_cycles", bc, 9);
    last8 = e.p;
    @(negedge clk);
    chk("n8_done_pulse", {31'h0, done8}, 0);
    chk("n8_idle_busy", {31'h0, busy8}, 0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    bit seen;
    exp_t e;
    mc4 = a;
    mp4 = b;
    st4 = 1;
    @(posedge clk);
    #1;
    e.p = 16'(a) * 16'(b);
    e.due = cyc + 4;
    q4.push_back(e);
    st4 = 0;
    mc4 = 4'($urandom);
    mp4 = 4'($urandom);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done4) seen = 1;
    end
    if (!seen) chk("n4_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int t;
    exp_t e;
    rst8_n = 0; st8 = 0; mc8 = 0; mp8 = 0;
    rst4_n = 0; st4 = 0; mc4 = 0; mp4 = 0;
    last8 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy8}, 0);
    chk("rst_done", {31'h0, done8}, 0);
    chk("rst_product", {16'h0, prod8}, 0);
    chk("rst4_product", {24'h0, prod4}, 0);
    rst8_n = 1;
    rst4_n = 1;
    @(negedge clk);

    op8(13, 11);
    op8(255, 255);
    op8(0, 200);
    op8(200, 0);

    // start held high, operands changed mid-CALC
    mc8 = 3; mp8 = 5; st8 = 1;
    @(posedge clk);
    #1;
    t = cyc;
    e.p = 16'h000F; e.due = t + 8;
    q8.push_back(e);
    e.p = 16'd10000; e.due = t + 18;
    q8.push_back(e);
    repeat (3) @(negedge clk);
    mc8 = 100; mp8 = 100;
    while (cyc < t + 10) @(posedge clk);
    #1;
    st8 = 0;
    repeat (10) @(negedge clk);
    chk("held_queue_empty", q8.size(), 0);
    last8 = 16'd10000;

    // reset on the 4th CALC cycle
    mc8 = 100; mp8 = 100; st8 = 1;
    @(posedge clk);
    #1;
    st8 = 0;
    repeat (4) @(negedge clk);
    rst8_n = 0;
    @(negedge clk);
    chk("abort_busy", {31'h0, busy8}, 0);
    chk("abort_done", {31'h0, done8}, 0);
    chk("abort_product", {16'h0, prod8}, 0);
    rst8_n = 1;
    last8 = 0;
    @(negedge clk);
    op8(7, 9);
    chk("after_abort", {16'h0, prod8}, 32'h3F);

    op8(6, 7);
    chk("b2b_first", {16'h0, prod8}, 32'h2A);
    op8(9, 9);
    chk("b2b_second", {16'h0, prod8}, 32'h51);

    for (int i = 0; i < 200; i++) op8(8'($urandom), 8'($urandom));

    op4(15, 15);
    chk("n4_max", {24'h0, prod4}, 32'hE1);
    for (int i = 0; i < 1000; i++) op4(4'($urandom), 4'($urandom));

    repeat (3) @(negedge clk);
    chk("n8_queue_drained", q8.size(), 0);
    chk("n4_queue_drained", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
